// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and helpers for the scanned 4-digit display driver.
package hex_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF     = 7'h7F;
  localparam logic [3:0] AN_OFF      = 4'hF;
  localparam int         DIGIT_IDX_W = 2;
  localparam int         NUM_DIGITS  = 4;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/hex_scan_driver_scan_timebase.sv
// Slot/digit/frame counters for the display scan: t runs within a slot,
// d selects the digit, the frame counter paces the blink half-period.
module scan_timebase
  import hex_scan_driver_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int BLINK_FRAMES = 125,
  parameter int T_W          = cnt_width(DIGIT_PERIOD)
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic [T_W-1:0]         t,
  output logic [DIGIT_IDX_W-1:0] d,
  output logic                   slot_start,
  output logic                   frame_end,
  output logic                   blink_tick
);

  localparam int F_W = cnt_width(BLINK_FRAMES);

  logic [F_W-1:0] frame_cnt;
  logic           slot_end;

  assign slot_start = (t == '0);
  assign slot_end   = (t == T_W'(DIGIT_PERIOD - 1));
  assign frame_end  = slot_end && (d == DIGIT_IDX_W'(NUM_DIGITS - 1));
  assign blink_tick = frame_end && (frame_cnt == F_W'(BLINK_FRAMES - 1));

  // Slot, digit and frame counters; d wraps 3 -> 0 by its own width.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      t         <= '0;
      d         <= '0;
      frame_cnt <= '0;
    end else begin
      if (slot_end) begin
        t <= '0;
        d <= d + DIGIT_IDX_W'(1);
      end else begin
        t <= t + T_W'(1);
      end
      if (blink_tick) begin
        frame_cnt <= '0;
      end else if (frame_end) begin
        frame_cnt <= frame_cnt + F_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes four 7-segment patterns onto one segment bus with
// guard blanking, per-frame input snapshot and per-digit blinking.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int GUARD_CYCLES = 2000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic [6:0] hex3_i,
  input  logic [6:0] hex2_i,
  input  logic [6:0] hex1_i,
  input  logic [6:0] hex0_i,
  input  logic [3:0] blink_mask_i,
  input  logic       blank_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       frame_start_o
);

  localparam int T_W = cnt_width(DIGIT_PERIOD);

  logic [T_W-1:0]                t;
  logic [DIGIT_IDX_W-1:0]        d;
  logic                          slot_start;
  logic                          frame_end;
  logic                          blink_tick;
  logic                          snap_en;
  logic                          dark;
  logic [NUM_DIGITS-1:0][6:0]    snap_seg;
  logic [NUM_DIGITS-1:0]         snap_mask;
  logic                          blink_phase;
  logic [3:0]                    an_next;
  logic [6:0]                    seg_next;

  scan_timebase #(
    .DIGIT_PERIOD (DIGIT_PERIOD),
    .BLINK_FRAMES (BLINK_FRAMES),
    .T_W          (T_W)
  ) u_timebase (
    .clk        (clk100_i),
    .rstn       (rstn_i),
    .t          (t),
    .d          (d),
    .slot_start (slot_start),
    .frame_end  (frame_end),
    .blink_tick (blink_tick)
  );

  assign snap_en = slot_start && (d == '0);

  // Anode/segment selection for the current state; the guard window keeps
  // adjacent digits from overlapping across a slot boundary.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dark     = (t < T_W'(GUARD_CYCLES)) || blank_i || (blink_phase && snap_mask[d]);
    if (dark) begin
      an_next  = AN_OFF;
      seg_next = SEG_OFF;
    end else begin
      an_next  = ~(4'b0001 << d);
      seg_next = snap_seg[d];
    end
  end

  // Snapshot, blink phase and registered outputs. frame_start_o is high in
  // the cycle whose state is t==0, d==0, i.e. one edge after frame_end.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      snap_seg      <= {NUM_DIGITS{SEG_OFF}};
      snap_mask     <= 4'h0;
      blink_phase   <= 1'b0;
      seg_o         <= SEG_OFF;
      an_o          <= AN_OFF;
      frame_start_o <= 1'b0;
    end else begin
      if (snap_en) begin
        snap_seg  <= {hex3_i, hex2_i, hex1_i, hex0_i};
        snap_mask <= blink_mask_i;
      end
      if (blink_tick) begin
        blink_phase <= ~blink_phase;
      end
      seg_o         <= seg_next;
      an_o          <= an_next;
      frame_start_o <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Randomized self-checking bench for hex_scan_driver against a
// cycle-count based reference model of the scan.
module tb_hex_scan_driver;

  localparam int DP    = 8;
  localparam int GC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DP;

  logic       clk100_i = 1'b0;
  logic       rstn_i;
  logic [6:0] hex3_i, hex2_i, hex1_i, hex0_i;
  logic [3:0] blink_mask_i;
  logic       blank_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       frame_start_o;

  always #5 clk100_i = ~clk100_i;

  hex_scan_driver #(
    .DIGIT_PERIOD (DP),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk100_i      (clk100_i),
    .rstn_i        (rstn_i),
    .hex3_i        (hex3_i),
    .hex2_i        (hex2_i),
    .hex1_i        (hex1_i),
    .hex0_i        (hex0_i),
    .blink_mask_i  (blink_mask_i),
    .blank_i       (blank_i),
    .seg_o         (seg_o),
    .an_o          (an_o),
    .frame_start_o (frame_start_o)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  // Model state: n = edges since reset release; snapshot of the frame's inputs.
  int         n           = 0;
  logic [6:0] m_snap [4]  = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [3:0] m_mask      = 4'h0;
  int         blank_left  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from position-in-frame arithmetic, clock, compare.
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [3:0] one;
    logic       e_fs;
    int         p, dd, tt, frame;
    bit         phase;
    one = 4'b0001;
    if (!rstn_i) begin
      e_seg  = 7'h7F;
      e_an   = 4'hF;
      e_fs   = 1'b0;
      n      = 0;
      m_snap = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
      m_mask = 4'h0;
    end else begin
      p     = n % FRAME;
      dd    = p / DP;
      tt    = p % DP;
      frame = n / FRAME;
      phase = ((frame / BF) % 2) == 1;
      if (tt < GC || blank_i || (phase && m_mask[dd])) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end else begin
        e_an  = ~(one << dd);
        e_seg = m_snap[dd];
      end
      e_fs = (p == FRAME - 1);
      if (p == 0) begin
        m_snap = '{hex0_i, hex1_i, hex2_i, hex3_i};
        m_mask = blink_mask_i;
      end
      n++;
    end
    @(posedge clk100_i);
    #1;
    check_eq("seg", {25'd0, seg_o}, {25'd0, e_seg});
    check_eq("an", {28'd0, an_o}, {28'd0, e_an});
    check_eq("frame_start", {31'd0, frame_start_o}, {31'd0, e_fs});
    check_eq("an_onehot", {31'd0, ($countones(~an_o) <= 1)}, 32'd1);
  endtask

  task automatic rand_hex();
    hex0_i = 7'($urandom);
    hex1_i = 7'($urandom);
    hex2_i = 7'($urandom);
    hex3_i = 7'($urandom);
  endtask

  initial begin
    rstn_i       = 1'b0;
    blank_i      = 1'b0;
    blink_mask_i = 4'h0;
    rand_hex();
    #1;
    // Reset held with toggling inputs.
    repeat (3) begin
      rand_hex();
      blink_mask_i = 4'($urandom);
      blank_i      = 1'($urandom);
      step();
    end

    // Pattern routing.
    rstn_i       = 1'b1;
    blank_i      = 1'b0;
    blink_mask_i = 4'h0;
    hex0_i = 7'h40; hex1_i = 7'h79; hex2_i = 7'h24; hex3_i = 7'h30;
    repeat (2 * FRAME) step();

    // Frame coherence: change digit 2 input while digit 1 is scanned.
    while (((n % FRAME) / DP) != 1) step();
    hex2_i = 7'h12;
    repeat (2 * FRAME) step();

    // Blink digit 2 across several blink half-periods.
    blink_mask_i = 4'b0100;
    repeat (6 * FRAME) step();
    blink_mask_i = 4'h0;

    // Blank for 10 cycles starting mid-slot.
    while ((n % DP) != 4) step();
    blank_i = 1'b1;
    repeat (10) step();
    blank_i = 1'b0;
    repeat (FRAME) step();

    // One-cycle reset at d=2, t=5.
    while ((n % FRAME) != 21) step();
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    repeat (2 * FRAME) step();

    // Random traffic: sporadic input edits, blank bursts, rare resets.
    repeat (2500) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       hex0_i = 7'($urandom);
          1:       hex1_i = 7'($urandom);
          2:       hex2_i = 7'($urandom);
          default: hex3_i = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) blink_mask_i = 4'($urandom);
      if (blank_left > 0) begin
        blank_left--;
        blank_i = 1'b1;
      end else begin
        blank_i = 1'b0;
        if ($urandom_range(0, 59) == 0) blank_left = int'($urandom_range(1, 12));
      end
      rstn_i = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
